// File: rtl/ledarray_pkg.sv
// Shared types and command encodings for the LED-array refresh sequencer.
package ledarray_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        XF_DATA_CMD,
        XF_CTRL,
        XF_WRITE
    } xfer_t;

    localparam int         NUM_ADDR          = 16;
    localparam logic [7:0] CMD_ONLY_POS      = 8'hFF;
    localparam logic [7:0] DATA_CMD_DEFAULT  = 8'h44;
    localparam logic [7:0] ADDR_BASE_DEFAULT = 8'hC0;

    function automatic logic [7:0] ctrl_cmd(input logic on, input logic [2:0] level);
        return {4'b1000, on, level};
    endfunction

endpackage

// File: rtl/ledarray_refresh_ctrl_if.sv
// Request/busy handshake between the refresh sequencer and the serial pixel writer.
interface ledarray_refresh_ctrl_if;

    logic       px_valid;
    logic [7:0] px_pos;
    logic [7:0] px_value;
    logic       px_busy;

    modport master (
        output px_valid,
        output px_pos,
        output px_value,
        input  px_busy
    );

    modport slave (
        input  px_valid,
        input  px_pos,
        input  px_value,
        output px_busy
    );

endinterface

// File: rtl/ledarray_dirty_pick.sv
// Rotating priority encoder: first set dirty bit at or after start, wrapping mod 16.
module ledarray_dirty_pick (
    input  logic [15:0] dirty,
    input  logic [3:0]  start,
    output logic        found,
    output logic [3:0]  addr
);

    logic [15:0] rotated;
    logic [3:0]  offset;

    // Rotate so that bit 0 corresponds to the start address.
    assign rotated = (dirty >> start) | (dirty << (5'd16 - {1'b0, start}));

    always_comb begin
        offset = '0;
        for (int i = 15; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = 4'(i);
            end
        end
    end

    assign found = |dirty;
    assign addr  = start + offset;

endmodule

// File: rtl/ledarray_refresh_ctrl.sv
// Frame-buffer refresh sequencer: sends init/brightness commands, then streams
// changed buffer bytes to the serial pixel writer one transfer at a time.
module ledarray_refresh_ctrl
    import ledarray_pkg::*;
#(
    parameter int         STARTUP_CYCLES = 1200,
    parameter int         ACK_TIMEOUT    = 64,
    parameter logic [7:0] DATA_CMD       = DATA_CMD_DEFAULT,
    parameter logic [7:0] ADDR_BASE      = ADDR_BASE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [3:0]               wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [2:0]               bright,
    input  logic                     disp_on,
    input  logic                     ctrl_we,
    input  logic                     refresh_all,
    ledarray_refresh_ctrl_if.master  px,
    output logic                     init_done,
    output logic                     idle
);

    localparam int CNT_MAX = (STARTUP_CYCLES > ACK_TIMEOUT) ? STARTUP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    xfer_t              kind;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         fb [NUM_ADDR];
    logic [15:0]        dirty;
    logic               ctrl_pending;
    logic [2:0]         bright_r;
    logic               disp_on_r;
    logic [3:0]         scan_ptr;
    logic [3:0]         cur_addr;

    logic               pick_found;
    logic [3:0]         pick_addr;
    logic               can_select;
    logic               take_ctrl;
    logic               take_write;
    logic [15:0]        set_mask;
    logic [15:0]        clr_mask;

    ledarray_dirty_pick u_pick (
        .dirty (dirty),
        .start (scan_ptr),
        .found (pick_found),
        .addr  (pick_addr)
    );

    // A selection only happens when the writer is free, so cleared bits always become a transfer.
    assign can_select = (state == ST_SELECT) && !px.px_busy;
    assign take_ctrl  = can_select && init_done && ctrl_pending;
    assign take_write = can_select && init_done && !ctrl_pending && pick_found;
    assign set_mask   = {16{refresh_all}} | (wr_en ? (16'b1 << wr_addr) : 16'b0);
    assign clr_mask   = take_write ? (16'b1 << pick_addr) : 16'b0;

    assign idle = (state == ST_SELECT) && init_done && !ctrl_pending && (dirty == 16'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ADDR; i++) begin
                fb[i] <= 8'h00;
            end
        end else if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    // Host sets win over a same-cycle clear, so a racing update is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty        <= '1;
            ctrl_pending <= 1'b1;
            bright_r     <= 3'd7;
            disp_on_r    <= 1'b1;
        end else begin
            dirty        <= (dirty & ~clr_mask) | set_mask;
            ctrl_pending <= (ctrl_pending & ~take_ctrl) | ctrl_we;
            if (ctrl_we) begin
                bright_r  <= bright;
                disp_on_r <= disp_on;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STARTUP;
            kind         <= XF_DATA_CMD;
            cnt          <= '0;
            px.px_valid  <= 1'b0;
            px.px_pos    <= CMD_ONLY_POS;
            px.px_value  <= 8'h00;
            init_done    <= 1'b0;
            scan_ptr     <= 4'd0;
            cur_addr     <= 4'd0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    if (cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_SELECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SELECT: begin
                    if (can_select) begin
                        if (!init_done) begin
                            px.px_pos   <= CMD_ONLY_POS;
                            px.px_value <= DATA_CMD;
                            kind        <= XF_DATA_CMD;
                        end else if (ctrl_pending) begin
                            px.px_pos   <= CMD_ONLY_POS;
                            px.px_value <= ctrl_cmd(disp_on_r, bright_r);
                            kind        <= XF_CTRL;
                        end else if (pick_found) begin
                            px.px_pos   <= ADDR_BASE | {4'b0000, pick_addr};
                            px.px_value <= fb[pick_addr];
                            kind        <= XF_WRITE;
                            cur_addr    <= pick_addr;
                        end
                        if (!init_done || ctrl_pending || pick_found) begin
                            px.px_valid <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    px.px_valid <= 1'b0;
                    cnt         <= '0;
                    state       <= ST_WAIT_ACK;
                end

                // Writer never saw the pulse: re-issue the same latched transfer.
                ST_WAIT_ACK: begin
                    if (px.px_busy) begin
                        cnt   <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        cnt         <= '0;
                        px.px_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!px.px_busy) begin
                        state <= ST_SELECT;
                        if (kind == XF_DATA_CMD) begin
                            init_done <= 1'b1;
                        end
                        if (kind == XF_WRITE) begin
                            scan_ptr <= cur_addr + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_STARTUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ledarray_refresh_ctrl.sv
// Randomized bench for ledarray_refresh_ctrl: a busy-frame writer model plus a
// transfer-order reference model that predicts the (pos, value) stream.
module tb_ledarray_refresh_ctrl;

    localparam int ACK_TO     = 64;
    localparam int BUSY_FRAME = 40;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] bright;
    logic       disp_on;
    logic       ctrl_we;
    logic       refresh_all;
    logic       init_done;
    logic       idle;

    logic       wr_busy;
    logic       hold;
    int         ignore_cnt = 0;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         wide_cnt = 0;
    logic       prev_v   = 1'b0;

    logic [16:0] obs_q [$];
    int          obs_cyc [$];
    logic [16:0] exp_q [$];

    logic [7:0]  m_fb [16];
    bit   [15:0] m_dirty;
    bit          m_ctrl;
    bit          m_on;
    logic [2:0]  m_bright;
    int          m_scan;
    bit          m_init;

    ledarray_refresh_ctrl_if bus ();

    assign bus.px_busy = wr_busy | hold;

    ledarray_refresh_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bright      (bright),
        .disp_on     (disp_on),
        .ctrl_we     (ctrl_we),
        .refresh_all (refresh_all),
        .px          (bus),
        .init_done   (init_done),
        .idle        (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Transfer monitor: log every valid pulse with the init_done seen alongside it.
    always @(negedge clk) begin
        if (bus.px_valid) begin
            obs_q.push_back({init_done, bus.px_pos, bus.px_value});
            obs_cyc.push_back(cyc);
            if (prev_v) wide_cnt++;
        end
        prev_v = bus.px_valid;
    end

    // Pixel writer model: busy for BUSY_FRAME cycles per accepted request.
    initial begin
        wr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.px_valid && rst_n) begin
                if (ignore_cnt > 0) begin
                    ignore_cnt--;
                end else begin
                    @(posedge clk);
                    #1 wr_busy = 1'b1;
                    repeat (BUSY_FRAME) @(posedge clk);
                    #1 wr_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] a, input logic [7:0] d,
                                 input logic cwe, input logic [2:0] b, input logic on,
                                 input logic ra);
        wr_en       = we;
        wr_addr     = a;
        wr_data     = d;
        ctrl_we     = cwe;
        bright      = b;
        disp_on     = on;
        refresh_all = ra;
        if (we) begin
            m_fb[a]    = d;
            m_dirty[a] = 1'b1;
        end
        if (ra) m_dirty = '1;
        if (cwe) begin
            m_ctrl   = 1'b1;
            m_bright = b;
            m_on     = on;
        end
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        ctrl_we     = 1'b0;
        refresh_all = 1'b0;
    endtask

    // Reference order: init command, then control, then dirty bytes round-robin from the scan pointer.
    task automatic predictDrain();
        bit any;
        if (!m_init) begin
            exp_q.push_back({1'b0, 8'hFF, 8'h44});
            m_init = 1'b1;
        end
        if (m_ctrl) begin
            exp_q.push_back({1'b1, 8'hFF, 4'b1000, m_on, m_bright});
            m_ctrl = 1'b0;
        end
        do begin
            any = 1'b0;
            for (int k = 0; k < 16; k++) begin
                int a;
                a = (m_scan + k) % 16;
                if (m_dirty[a]) begin
                    exp_q.push_back({1'b1, 8'hC0 | 8'(a), m_fb[a]});
                    m_dirty[a] = 1'b0;
                    m_scan     = (a + 1) % 16;
                    any        = 1'b1;
                    break;
                end
            end
        end while (any);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (!idle && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic checkTransfers(input string tag, input int budget);
        int n;
        waitIdle(budget, tag);
        checkOutput({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_xfer"}, 32'(obs_q[i]), 32'(exp_q[i]));
        end
        checkOutput({tag, "_valid_width"}, 32'(wide_cnt), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int gap;
        int n;
        logic [3:0] a;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bright = '0; disp_on = 1'b0; ctrl_we = 1'b0; refresh_all = 1'b0; hold = 1'b0;
        for (int i = 0; i < 16; i++) m_fb[i] = 8'h00;
        m_dirty = '1; m_ctrl = 1'b1; m_on = 1'b1; m_bright = 3'd7; m_scan = 0; m_init = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.px_valid), 32'd0);
        checkOutput("rst_pos", 32'(bus.px_pos), 32'hFF);
        checkOutput("rst_value", 32'(bus.px_value), 32'h00);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_idle", 32'(idle), 32'd0);
        rst_n = 1'b1;

        predictDrain();
        checkTransfers("startup", 6000);
        checkOutput("startup_init_done", 32'(init_done), 32'd1);

        // Control command must outrank already-dirty bytes.
        hold = 1'b1;
        applyStimulus(1'b1, 4'd2, 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 8'($urandom), 1'b1, 3'd2, 1'b1, 1'b0);
        hold = 1'b0;
        predictDrain();
        checkTransfers("ctrl_prio", 1000);

        applyStimulus(1'b1, 4'd5, 8'hA5, 1'b0, 3'd0, 1'b0, 1'b0);
        predictDrain();
        checkTransfers("single_write", 500);

        // Rewrite of the byte currently being sent must be sent again.
        applyStimulus(1'b1, 4'd3, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0);
        predictDrain();
        n = 0;
        while (obs_q.size() == 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(1'b1, 4'd3, 8'h22, 1'b0, 3'd0, 1'b0, 1'b0);
        predictDrain();
        checkTransfers("inflight", 1000);

        applyStimulus(1'b1, 4'd13, 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        predictDrain();
        checkTransfers("wrap_prep", 500);
        hold = 1'b1;
        applyStimulus(1'b1, 4'd1, 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd14, 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        hold = 1'b0;
        predictDrain();
        checkTransfers("wrap", 1000);

        for (int r = 0; r < 4; r++) begin
            hold = 1'b1;
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                applyStimulus(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 3'd0, 1'b0,
                              ($urandom_range(0, 7) == 0));
            end
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b0, 4'd0, 8'd0, 1'b1, 3'($urandom), 1'($urandom), 1'b0);
            end
            hold = 1'b0;
            predictDrain();
            checkTransfers("random", 4000);
        end

        // Writer drops the first request; the identical transfer must be re-pulsed.
        ignore_cnt = 1;
        obs_cyc.delete();
        a = 4'($urandom_range(0, 15));
        applyStimulus(1'b1, a, 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        predictDrain();
        exp_q.push_back(exp_q[exp_q.size() - 1]);
        checkTransfers("ack_timeout", 1000);
        gap = (obs_cyc.size() >= 2) ? (obs_cyc[1] - obs_cyc[0]) : 0;
        checkOutput("ack_gap_ok", 32'(gap >= ACK_TO && gap <= ACK_TO + 2), 32'd1);

        applyStimulus(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 3'd0, 1'b0, 1'b0);
        n = 0;
        while (obs_q.size() == 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rst_mid_seen", 32'(obs_q.size() > 0), 32'd1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 32'(bus.px_valid), 32'd0);
        checkOutput("rst_mid_pos", 32'(bus.px_pos), 32'hFF);
        checkOutput("rst_mid_value", 32'(bus.px_value), 32'h00);
        checkOutput("rst_mid_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_mid_idle", 32'(idle), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
